// File: rtl/multdiv_controller.sv
// Sequences the shared mult/div unit from X: detect, one-cycle start pulse, stall until RDY or timeout.
// Start pulse one cycle after detection, done one cycle after RDY (or TIMEOUT_CYCLES+2 after detection); stall is combinational.
module multdiv_controller #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ExecuteIR,
  input  logic        ex_valid,
  input  logic [31:0] ExecuteA,
  input  logic [31:0] ExecuteB,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic        md_stall,
  output logic        md_done,
  output logic [31:0] md_result,
  output logic        md_exception,
  output logic        md_timeout,
  output logic [1:0]  md_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    BUSY  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       OPC_MULT = 5'b00110;
  localparam logic [4:0]       OPC_DIV  = 5'b00111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ctrl_mult_q, ctrl_mult_d;
  logic             ctrl_div_q, ctrl_div_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             done_q, done_d;
  logic [31:0]      result_q, result_d;
  logic             exc_q, exc_d;
  logic             tmo_q, tmo_d;

  logic       is_md;
  logic       is_div;
  logic [4:0] opc;
  logic       ir_unused;

  assign opc       = ExecuteIR[6:2];
  assign is_div    = (opc == OPC_DIV);
  assign is_md     = ex_valid & (ExecuteIR[31:27] == 5'd0) & ((opc == OPC_MULT) | is_div);
  assign ir_unused = ^{ExecuteIR[26:7], ExecuteIR[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    opa_d       = opa_q;
    opb_d       = opb_q;
    done_d      = 1'b0;
    result_d    = result_q;
    exc_d       = exc_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        if (is_md) begin
          opa_d       = ExecuteA;
          opb_d       = ExecuteB;
          ctrl_mult_d = ~is_div;
          ctrl_div_d  = is_div;
          state_d     = START;
        end
      end
      START: begin
        // RDY seen here belongs to a previous operation and is ignored.
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (data_resultRDY) begin
          result_d = data_result;
          exc_d    = data_exception;
          tmo_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          exc_d    = 1'b1;
          tmo_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      done_q      <= done_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      tmo_q       <= tmo_d;
    end
  end

  // Stall is forced low during reset so the pipeline is not frozen by a stale detection.
  assign md_stall      = reset & (((state_q == IDLE) & is_md) | (state_q == START) | (state_q == BUSY));
  assign ctrl_MULT     = ctrl_mult_q;
  assign ctrl_DIV      = ctrl_div_q;
  assign data_operandA = opa_q;
  assign data_operandB = opb_q;
  assign md_done       = done_q;
  assign md_result     = result_q;
  assign md_exception  = exc_q;
  assign md_timeout    = tmo_q;
  assign md_state      = state_q;

endmodule

// File: tb/tb_multdiv_controller.sv
// Randomized and directed bench for multdiv_controller; expected timing is derived from detection/RDY offsets.
module tb_multdiv_controller;

  localparam int TO = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ExecuteIR;
  logic        ex_valid;
  logic [31:0] ExecuteA, ExecuteB;
  logic        data_resultRDY, data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic        md_stall, md_done;
  logic [31:0] md_result;
  logic        md_exception, md_timeout;
  logic [1:0]  md_state;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multdiv_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .ExecuteIR(ExecuteIR), .ex_valid(ex_valid),
    .ExecuteA(ExecuteA), .ExecuteB(ExecuteB), .data_resultRDY(data_resultRDY),
    .data_exception(data_exception), .data_result(data_result),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .md_stall(md_stall), .md_done(md_done), .md_result(md_result),
    .md_exception(md_exception), .md_timeout(md_timeout), .md_state(md_state)
  );

  function automatic logic [31:0] md_ir(input bit div);
    logic [31:0] ir;
    ir        = $urandom;
    ir[31:27] = 5'd0;
    ir[6:2]   = div ? 5'b00111 : 5'b00110;
    return ir;
  endfunction

  function automatic logic [31:0] alu_ir();
    logic [31:0] ir;
    ir        = $urandom;
    ir[31:27] = 5'd0;
    ir[6:2]   = 5'b00000;
    return ir;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Drives one mult/div from detection (offset 0) until DONE and reports what was observed.
  // rdy_at: offset at which RDY is raised (-1 = never); start_noise adds a stray RDY in the START cycle.
  task automatic run_txn(input bit div, input logic [31:0] a, input logic [31:0] b,
                         input int rdy_at, input logic [31:0] res, input logic exc, input bit start_noise,
                         output int done_off, output int stall_cnt, output int mult_n, output int div_n,
                         output int pulse_off, output int done_n,
                         output logic [31:0] opa_seen, output logic [31:0] opb_seen,
                         output logic [31:0] r0, output logic [31:0] r, output logic e, output logic t,
                         output logic [1:0] st1, output logic [1:0] st2,
                         output bit held_ok, output bit ops_stable);
    done_off = -1; stall_cnt = 0; mult_n = 0; div_n = 0; pulse_off = -1; done_n = 0;
    opa_seen = 'x; opb_seen = 'x; r0 = 'x; r = 'x; e = 'x; t = 'x; st1 = 'x; st2 = 'x;
    held_ok = 1'b1; ops_stable = 1'b1;
    ExecuteIR = md_ir(div); ex_valid = 1'b1; ExecuteA = a; ExecuteB = b;
    data_resultRDY = 1'b0; data_result = $urandom; data_exception = 1'($urandom);
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (k == 0) r0 = md_result;
      if (md_stall) stall_cnt++;
      if (ctrl_MULT) begin mult_n++; pulse_off = k; opa_seen = data_operandA; opb_seen = data_operandB; end
      if (ctrl_DIV)  begin div_n++;  pulse_off = k; opa_seen = data_operandA; opb_seen = data_operandB; end
      if (pulse_off >= 0 && (data_operandA !== opa_seen || data_operandB !== opb_seen)) ops_stable = 1'b0;
      if (k == 1) st1 = md_state;
      if (k == 2) st2 = md_state;
      if (md_done) done_n++;
      if (md_done) begin
        done_off = k; r = md_result; e = md_exception; t = md_timeout;
        break;
      end else if (md_result !== r0) begin
        held_ok = 1'b0;
      end
      next_cycle();
      // Bypassed operands may change while X is frozen; the latched copies must not.
      ExecuteA       = $urandom;
      ExecuteB       = $urandom;
      data_resultRDY = (k + 1 == rdy_at) || (start_noise && k + 1 == 1);
      data_result    = (k + 1 == rdy_at) ? res : 32'($urandom);
      data_exception = (k + 1 == rdy_at) ? exc : 1'($urandom);
    end
    data_resultRDY = 1'b0;
  endtask

  int d, sc, mn, dn, po, dnn;
  logic [31:0] oa, ob, r0, rr;
  logic ee, tt;
  logic [1:0] s1, s2;
  bit hok, ost;

  task automatic test_reset();
    reset = 1'b0; ex_valid = 1'b1; ExecuteIR = md_ir(0); ExecuteA = $urandom; ExecuteB = $urandom;
    data_resultRDY = 1'b0; data_result = '0; data_exception = 1'b0;
    repeat (3) next_cycle();
    total++; if ({ctrl_MULT, ctrl_DIV, md_done, md_exception, md_timeout, md_stall} !== 6'b0) begin
      bad++; $display("FAIL rst_flags got=%b exp=000000", {ctrl_MULT, ctrl_DIV, md_done, md_exception, md_timeout, md_stall}); end
    total++; if ({data_operandA, data_operandB, md_result} !== 96'b0) begin
      bad++; $display("FAIL rst_data got=%h_%h_%h exp=0", data_operandA, data_operandB, md_result); end
    total++; if (md_state !== 2'b00) begin bad++; $display("FAIL rst_state got=%b exp=00", md_state); end
    ExecuteIR = alu_ir(); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++; if ({md_stall, md_state, ctrl_MULT, ctrl_DIV, md_done} !== 6'b0) begin
        bad++; $display("FAIL alu_no_stall cyc=%0d got=%b exp=000000", i, {md_stall, md_state, ctrl_MULT, ctrl_DIV, md_done}); end
      next_cycle();
      ExecuteIR = alu_ir();
    end
    ex_valid = 1'b0; ExecuteIR = md_ir(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++; if ({md_stall, md_state} !== 3'b0) begin
        bad++; $display("FAIL bubble_no_stall cyc=%0d got=%b exp=000", i, {md_stall, md_state}); end
      next_cycle();
    end
    ex_valid = 1'b1; ExecuteIR = md_ir(1); ExecuteIR[31:27] = 5'b00100;
    @(negedge clock);
    total++; if ({md_stall, md_state} !== 3'b0) begin
      bad++; $display("FAIL nonrtype_no_stall got=%b exp=000", {md_stall, md_state}); end
    next_cycle();
    ex_valid = 1'b0;
  endtask

  task automatic test_mult();
    next_cycle();
    run_txn(0, 32'd6, 32'd7, 18, 32'd42, 1'b0, 1'b0, d, sc, mn, dn, po, dnn, oa, ob, r0, rr, ee, tt, s1, s2, hok, ost);
    total++; if (d !== 19) begin bad++; $display("FAIL mult_done_off got=%0d exp=19", d); end
    total++; if (sc !== 19) begin bad++; $display("FAIL mult_stall_cycles got=%0d exp=19", sc); end
    total++; if (mn !== 1 || dn !== 0 || po !== 1) begin
      bad++; $display("FAIL mult_pulses got=mult%0d/div%0d@%0d exp=1/0@1", mn, dn, po); end
    total++; if (oa !== 32'd6 || ob !== 32'd7) begin bad++; $display("FAIL mult_operands got=%0d/%0d exp=6/7", oa, ob); end
    total++; if (rr !== 32'd42) begin bad++; $display("FAIL mult_result got=%0d exp=42", rr); end
    total++; if ({ee, tt} !== 2'b00) begin bad++; $display("FAIL mult_exc_tmo got=%b exp=00", {ee, tt}); end
    total++; if (s1 !== 2'b01 || s2 !== 2'b10) begin bad++; $display("FAIL mult_states got=%b/%b exp=01/10", s1, s2); end
    total++; if (dnn !== 1 || !ost) begin bad++; $display("FAIL mult_done_once_ops_stable got=%0d/%0d exp=1/1", dnn, ost); end
    ex_valid = 1'b0;
  endtask

  task automatic test_div();
    logic [31:0] res;
    res = $urandom;
    next_cycle();
    run_txn(1, 32'd10, 32'd0, 5, res, 1'b1, 1'b0, d, sc, mn, dn, po, dnn, oa, ob, r0, rr, ee, tt, s1, s2, hok, ost);
    total++; if (d !== 6) begin bad++; $display("FAIL div_done_off got=%0d exp=6", d); end
    total++; if (dn !== 1 || mn !== 0 || po !== 1) begin
      bad++; $display("FAIL div_pulses got=div%0d/mult%0d@%0d exp=1/0@1", dn, mn, po); end
    total++; if (oa !== 32'd10 || ob !== 32'd0) begin bad++; $display("FAIL div_operands got=%0d/%0d exp=10/0", oa, ob); end
    total++; if ({ee, tt} !== 2'b10 || rr !== res) begin
      bad++; $display("FAIL div_exc got=exc%b tmo%b res%h exp=exc1 tmo0 res%h", ee, tt, rr, res); end
    ex_valid = 1'b0;
  endtask

  task automatic test_timeout();
    logic [31:0] res;
    next_cycle();
    run_txn(0, $urandom, $urandom, -1, 32'd0, 1'b0, 1'b0, d, sc, mn, dn, po, dnn, oa, ob, r0, rr, ee, tt, s1, s2, hok, ost);
    total++; if (d !== TO + 2) begin bad++; $display("FAIL tmo_done_off got=%0d exp=%0d", d, TO + 2); end
    total++; if (sc !== TO + 2) begin bad++; $display("FAIL tmo_stall_cycles got=%0d exp=%0d", sc, TO + 2); end
    total++; if (rr !== 32'd0 || {ee, tt} !== 2'b11) begin
      bad++; $display("FAIL tmo_outputs got=res%h exc%b tmo%b exp=res0 exc1 tmo1", rr, ee, tt); end
    res = $urandom;
    next_cycle();
    run_txn(0, $urandom, $urandom, TO + 1, res, 1'b0, 1'b0, d, sc, mn, dn, po, dnn, oa, ob, r0, rr, ee, tt, s1, s2, hok, ost);
    total++; if (d !== TO + 2) begin bad++; $display("FAIL lastcyc_done_off got=%0d exp=%0d", d, TO + 2); end
    total++; if (rr !== res || {ee, tt} !== 2'b00) begin
      bad++; $display("FAIL lastcyc_outputs got=res%h exc%b tmo%b exp=res%h exc0 tmo0", rr, ee, tt, res); end
    ex_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res1, res2, a2, b2;
    int ra, rb;
    res1 = $urandom; res2 = $urandom; a2 = $urandom; b2 = $urandom;
    ra = $urandom_range(2, 12); rb = $urandom_range(2, 12);
    next_cycle();
    run_txn(0, $urandom, $urandom, ra, res1, 1'b0, 1'b1, d, sc, mn, dn, po, dnn, oa, ob, r0, rr, ee, tt, s1, s2, hok, ost);
    total++; if (d !== ra + 1 || rr !== res1) begin
      bad++; $display("FAIL b2b_first got=off%0d res%h exp=off%0d res%h", d, rr, ra + 1, res1); end
    next_cycle();
    run_txn(1, a2, b2, rb, res2, 1'b1, 1'b1, d, sc, mn, dn, po, dnn, oa, ob, r0, rr, ee, tt, s1, s2, hok, ost);
    total++; if (po !== 1 || dn !== 1 || oa !== a2 || ob !== b2) begin
      bad++; $display("FAIL b2b_second_start got=@%0d div%0d %h/%h exp=@1 div1 %h/%h", po, dn, oa, ob, a2, b2); end
    total++; if (r0 !== res1 || !hok) begin
      bad++; $display("FAIL b2b_result_held got=%h held%0d exp=%h held1", r0, hok, res1); end
    total++; if (d !== rb + 1 || rr !== res2 || ee !== 1'b1) begin
      bad++; $display("FAIL b2b_second got=off%0d res%h exc%b exp=off%0d res%h exc1", d, rr, ee, rb + 1, res2); end
    ex_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [31:0] res;
    res = $urandom;
    next_cycle();
    ExecuteIR = md_ir(0); ex_valid = 1'b1; ExecuteA = $urandom; ExecuteB = $urandom; data_resultRDY = 1'b0;
    repeat (6) next_cycle();
    total++; if (md_state !== 2'b10) begin bad++; $display("FAIL midop_busy got=%b exp=10", md_state); end
    reset = 1'b0;
    #1;
    total++; if ({md_stall, md_state, ctrl_MULT, ctrl_DIV, md_done, md_exception, md_timeout} !== 8'b0 ||
                 {data_operandA, data_operandB, md_result} !== 96'b0) begin
      bad++; $display("FAIL midop_async_clear got=%b %h %h %h exp=0", {md_stall, md_state, ctrl_MULT, ctrl_DIV,
                      md_done, md_exception, md_timeout}, data_operandA, data_operandB, md_result); end
    next_cycle();
    reset = 1'b1;
    run_txn(0, 32'd3, 32'd9, 4, res, 1'b0, 1'b0, d, sc, mn, dn, po, dnn, oa, ob, r0, rr, ee, tt, s1, s2, hok, ost);
    total++; if (mn !== 1 || po !== 1 || oa !== 32'd3 || ob !== 32'd9) begin
      bad++; $display("FAIL midop_reissue got=mult%0d@%0d %0d/%0d exp=1@1 3/9", mn, po, oa, ob); end
    total++; if (d !== 5 || rr !== res) begin bad++; $display("FAIL midop_done got=off%0d res%h exp=off5 res%h", d, rr, res); end
    ex_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      bit div, noise, timed;
      int rdy_at, exp_d;
      logic [31:0] a, b, res;
      logic exc;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        next_cycle();
        ex_valid  = 1'($urandom);
        ExecuteIR = ex_valid ? alu_ir() : md_ir(1'($urandom));
        @(negedge clock);
        total++; if ({md_stall, md_done} !== 2'b00) begin
          bad++; $display("FAIL rnd_gap it=%0d got=%b exp=00", it, {md_stall, md_done}); end
      end
      div = 1'($urandom); noise = 1'($urandom); a = $urandom; b = $urandom; res = $urandom; exc = 1'($urandom);
      rdy_at = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(2, TO + 5));
      timed  = !(rdy_at >= 2 && rdy_at <= TO + 1);
      exp_d  = timed ? TO + 2 : rdy_at + 1;
      next_cycle();
      run_txn(div, a, b, rdy_at, res, exc, noise, d, sc, mn, dn, po, dnn, oa, ob, r0, rr, ee, tt, s1, s2, hok, ost);
      total++; if (d !== exp_d || sc !== exp_d) begin
        bad++; $display("FAIL rnd_timing it=%0d got=done%0d stall%0d exp=%0d rdy_at=%0d", it, d, sc, exp_d, rdy_at); end
      total++; if (mn !== (div ? 0 : 1) || dn !== (div ? 1 : 0) || po !== 1) begin
        bad++; $display("FAIL rnd_pulse it=%0d got=mult%0d div%0d @%0d exp div=%0d @1", it, mn, dn, po, div); end
      total++; if (oa !== a || ob !== b || !ost) begin
        bad++; $display("FAIL rnd_operands it=%0d got=%h/%h stable%0d exp=%h/%h", it, oa, ob, ost, a, b); end
      total++; if (rr !== (timed ? 32'd0 : res) || ee !== (timed ? 1'b1 : exc) || tt !== timed) begin
        bad++; $display("FAIL rnd_result it=%0d got=%h exc%b tmo%b exp=%h exc%b tmo%b", it, rr, ee, tt,
                        timed ? 32'd0 : res, timed ? 1'b1 : exc, timed); end
      total++; if (!hok || dnn !== 1 || s1 !== 2'b01 || s2 !== 2'b10) begin
        bad++; $display("FAIL rnd_misc it=%0d got=held%0d done%0d st%b/%b exp=1 1 01/10", it, hok, dnn, s1, s2); end
      ex_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multdiv_controller.md
# multdiv_controller

Sequences the shared multi-cycle multiply/divide unit from the execute stage of the 5-stage pipeline. It detects an R-type `mult`/`div` in X, latches the bypassed operands, and issues a one-cycle start pulse to the unit. It holds the pipeline stall until the unit reports ready or a timeout expires, then presents the registered result and exception flag for the X/M latch.

## Interface
- `TIMEOUT_CYCLES`, default 40: maximum BUSY cycles before forced completion.
- `CNT_W`, default 6: counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ExecuteIR` in 32: instruction in X.
- `ex_valid` in 1: X holds a real instruction, not a bubble.
- `ExecuteA`, `ExecuteB` in 32: bypassed operands in X.
- `data_resultRDY` in 1: unit result ready.
- `data_exception` in 1: unit exception (div by zero / overflow), valid with RDY.
- `data_result` in 32: unit result.
- `ctrl_MULT`, `ctrl_DIV` out 1: registered one-cycle start pulses.
- `data_operandA`, `data_operandB` out 32: registered operands, held stable from START until the next detection.
- `md_stall` out 1: freeze F, D and X; combinational.
- `md_done` out 1: one-cycle pulse; result valid for the X/M latch.
- `md_result` out 32: registered result, held until the next DONE.
- `md_exception` out 1: registered, held like `md_result`.
- `md_timeout` out 1: registered, held like `md_result`.
- `md_state` out 2: current state, debug only.

## Operation
- Detection: `is_md = ex_valid & ExecuteIR[31:27]==0 & ExecuteIR[6:2] ∈ {00110 (mult), 00111 (div)}`. Sampled in IDLE only; `ExecuteIR` is ignored in all other states.
- State encoding: IDLE=00, START=01, BUSY=10, DONE=11.
- IDLE:
  - If `is_md`: latch `ExecuteA`/`ExecuteB` into the operand registers, record op (mult/div), go to START.
  - Otherwise stay in IDLE.
- START:
  - `ctrl_MULT` or `ctrl_DIV` is high this cycle only, per the recorded op.
  - Clear counter, go to BUSY.
  - `data_resultRDY` in START is stale and ignored.
- BUSY:
  - On `data_resultRDY`: capture `data_result` into `md_result`, `data_exception` into `md_exception`, set `md_timeout`=0, go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: set `md_result`=0, `md_exception`=1, `md_timeout`=1, go to DONE.
  - Else increment counter.
  - RDY and timeout in the same cycle: RDY wins.
- DONE: `md_done`=1, go to IDLE unconditionally. The mult/div leaves X at this edge. No detection in DONE.
- `md_stall = reset & ((state==IDLE & is_md) | state==START | state==BUSY)`. Low in DONE, and forced low while reset is asserted.
- Arithmetic: counter is unsigned CNT_W bits and never wraps, because it is bounded by the timeout. Operands and result pass through unmodified (32-bit two's complement).

## Timing
- Reset (asynchronous, `reset`=0): state=IDLE, counter=0. All registered outputs are 0: `ctrl_*`, `data_operand*`, `md_done`, `md_result`, `md_exception`, `md_timeout`. `md_state`=00, `md_stall`=0.
- Reset mid-operation: returns to IDLE immediately and abandons the in-flight unit operation. After release, a mult/div still in X is re-detected and re-issued.
- Detection at cycle T:
  - `md_stall` high in T (combinational).
  - START at T+1, with the `ctrl_*` pulse at T+1.
  - BUSY from T+2.
- RDY sampled at cycle R ≥ T+2: DONE in R+1, `md_stall` low in R+1, `md_done` high in R+1. Total stall cycles = R−T+1.
- Timeout: RDY never arrives → DONE at T+2+TIMEOUT_CYCLES. Stall cycles = TIMEOUT_CYCLES+2.
- Back-to-back mult/div: the earliest re-detection is R+2 (IDLE after DONE), giving one unstalled cycle between.

## Test plan
- Reset, then release with a non-md R-type (ALU op 00000) and `ex_valid`=1 → `md_stall`=0, state stays IDLE, all outputs 0. Same with `ex_valid`=0 and a mult IR → no stall.
- mult, A=6, B=7; unit raises RDY with result 42 on the 17th BUSY cycle →
  - `ctrl_MULT` pulse at T+1 with operands 6/7.
  - Stall high T..T+18; `md_done` and `md_result`=42 at T+19.
  - `md_exception`=0; `ctrl_DIV` never asserted.
- div, A=10, B=0; RDY with `data_exception`=1 at T+5 → `ctrl_DIV` at T+1, `md_done` at T+6, `md_exception`=1, `md_timeout`=0.
- mult with RDY held low, TIMEOUT_CYCLES=40 → `md_done` at T+42, `md_result`=0, `md_exception`=1, `md_timeout`=1. With RDY instead on the last counted cycle (T+41) → normal completion, `md_timeout`=0.
- mult then div back-to-back; RDY pulses also injected during START → START-cycle RDY ignored. Second detection at R+2 with new operands; first result held until the second DONE.
- Assert `reset` in BUSY at T+6 → outputs 0 asynchronously. After release with the mult still in X: re-detect, fresh `ctrl_MULT` pulse one cycle later.
